ahb3lite_sram_slave: RTL

AHB3-Lite responder with single-port word-organized SRAM behind it. It is the far end of the DMA master ports (m0H*/m1H*): memory the DMA engine reads from and writes to. Programmable wait states let the DMA's bridged master path be exercised under stall. An optional error path handles illegal accesses.

---
 rtl/ahb3lite_sram_slave.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite responder in front of a byte-lane SRAM, with programmable wait states.
// Define AHB3LITE_SRAM_ERR_EN to enable the two-cycle ERROR response for illegal accesses.
`timescale 1ns/1ps
module ahb3lite_sram_slave #(
    parameter int MEM_DEPTH   = 1024,  // words; must be a power of two
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sHSEL,
    input  logic [31:0] sHADDR,
    input  logic [31:0] sHWDATA,
    output logic [31:0] sHRDATA,
    input  logic        sHWRITE,
    input  logic [2:0]  sHSIZE,
    input  logic [2:0]  sHBURST,
    input  logic [3:0]  sHPROT,
    input  logic [1:0]  sHTRANS,
    input  logic        sHREADY,
    output logic        sHREADYOUT,
    output logic        sHRESP
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

`ifdef AHB3LITE_SRAM_ERR_EN
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
`else
    typedef enum logic [0:0] {IDLE, WAIT} state_t;
`endif

    state_t        state_reg;
    state_t        launch_state;
    logic [3:0]    cnt_reg;
    logic          dp_valid_reg;
    logic          write_reg;
    logic [3:0]    lanes_reg;
    logic [AW-1:0] idx_reg;
    logic          accept;
    logic          illegal;
    logic          ready;
    logic          mem_we;
    logic [3:0]    lanes_next;
    logic [31:0]   rd_word;
    logic          unused;

    assign accept = sHSEL & sHREADY & sHTRANS[1];

    always_comb begin
        case (sHSIZE)
            3'd0:    lanes_next = 4'b0001 << sHADDR[1:0];
            3'd1:    lanes_next = sHADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes_next = 4'b1111;
        endcase
    end

`ifdef AHB3LITE_SRAM_ERR_EN
    assign illegal = (sHSIZE > 3'd2)
                  || (sHSIZE == 3'd1 && sHADDR[0])
                  || (sHSIZE == 3'd2 && sHADDR[1:0] != 2'b00)
                  || (sHADDR[31:AW+2] != '0);
    assign sHRESP  = (state_reg == ERR1) || (state_reg == ERR2);
    assign ready   = !((state_reg == WAIT && cnt_reg != WS) || state_reg == ERR1);
    assign unused  = ^{sHBURST, sHPROT, sHTRANS[0]};
`else
    assign illegal = 1'b0;
    assign sHRESP  = 1'b0;
    assign ready   = !(state_reg == WAIT && cnt_reg != WS);
    assign unused  = ^{sHBURST, sHPROT, sHTRANS[0], sHADDR[31:AW+2]};
`endif

    // State entered on a ready edge, depending on what the address phase carries.
    always_comb begin
        launch_state = IDLE;
        if (accept && WAIT_STATES > 0)
            launch_state = WAIT;
`ifdef AHB3LITE_SRAM_ERR_EN
        if (accept && illegal)
            launch_state = ERR1;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            dp_valid_reg <= 1'b0;
            write_reg    <= 1'b0;
            lanes_reg    <= '0;
            idx_reg      <= '0;
        end else if (ready) begin
            state_reg    <= launch_state;
            cnt_reg      <= '0;
            dp_valid_reg <= accept && !illegal;
            if (accept) begin
                write_reg <= sHWRITE;
                lanes_reg <= lanes_next;
                idx_reg   <= sHADDR[AW+1:2];
            end
        end else begin
`ifdef AHB3LITE_SRAM_ERR_EN
            if (state_reg == ERR1)
                state_reg <= ERR2;
`endif
            if (state_reg == WAIT)
                cnt_reg <= cnt_reg + 4'd1;
        end
    end

    // Write data is only valid on the completing edge of the data phase.
    assign mem_we     = dp_valid_reg & write_reg & ready;
    assign sHREADYOUT = ready;
    assign sHRDATA    = (dp_valid_reg && !write_reg) ? rd_word : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];

            always_ff @(posedge clk_i) begin
                if (mem_we && lanes_reg[gi])
                    lane_mem[idx_reg] <= sHWDATA[gi*8 +: 8];
            end

            assign rd_word[gi*8 +: 8] = lane_mem[idx_reg];
        end
    endgenerate

endmodule
